// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, default width and
// a width helper used for the round-robin pointer and grant index.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_OR  = 2'b10,
        ALU_NOP = 2'b11
    } alu_op_e;

    localparam int DW_DEFAULT = 32;

    // Bits needed to hold an index in [0, value-1]; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin picker: grants the first eligible requester at or
// after the pointer, wrapping around. At most one grant is ever asserted.
module rr_pick
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    // Scan from the pointer; the first eligible hit wins and masks the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!grant_any && eligible[(int'(ptr) + off) % NREQ]) begin
                grant[(int'(ptr) + off) % NREQ] = 1'b1;
                grant_idx = PW'((int'(ptr) + off) % NREQ);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// One 32-bit ALU (ADD/SUB/OR/NOP) shared by NREQ requesters under round-robin
// arbitration, with one registered response slot per requester.
// Handshake: a request transfers when req_valid[i] && req_ready[i]; a response
// transfers when rsp_valid[i] && rsp_ready[i]. A full slot may be drained and
// refilled in the same cycle, so a requester can be served every cycle.
// Build option ALU_ARB_OVF_TRAP_EN: an overflowing ADD/SUB returns data 0 with
// ovf set (exception response) instead of the wrapped result.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [DW*NREQ-1:0]   req_a,
    input  logic [DW*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [DW*NREQ-1:0]   rsp_data,
    output logic [NREQ-1:0]      rsp_zero,
    output logic [NREQ-1:0]      rsp_ovf
);

    localparam int PW = clog2(NREQ);

    logic [PW-1:0]   ptr_q;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;

    alu_op_e         op_sel;
    logic [DW-1:0]   a_sel;
    logic [DW-1:0]   b_sel;
    logic [DW:0]     a_ext;
    logic [DW:0]     b_ext;
    logic [DW:0]     sum;
    logic [DW-1:0]   alu_data;
    logic            alu_zero;
    logic            alu_ovf;

    // A requester may issue when its slot is empty or being drained; nothing is
    // accepted while reset is held since the slot would be dropped anyway.
    always_comb begin
        eligible = rst ? '0 : (req_valid & (~rsp_valid | rsp_ready));
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    // Steer the granted requester's op and operands into the shared ALU.
    always_comb begin
        op_sel = alu_op_e'(req_op[int'(grant_idx)*2 +: 2]);
        a_sel  = req_a[int'(grant_idx)*DW +: DW];
        b_sel  = req_b[int'(grant_idx)*DW +: DW];
    end

    // Shared ALU: operands sign-extended by one bit so overflow is visible as
    // disagreement between the top two bits of the result.
    always_comb begin
        a_ext = {a_sel[DW-1], a_sel};
        b_ext = {b_sel[DW-1], b_sel};
        case (op_sel)
            ALU_ADD: sum = a_ext + b_ext;
            ALU_SUB: sum = a_ext - b_ext;
            ALU_OR:  sum = a_ext | b_ext;
            default: sum = '0;
        endcase
        alu_ovf  = ((op_sel == ALU_ADD) || (op_sel == ALU_SUB)) && (sum[DW] ^ sum[DW-1]);
        alu_zero = (a_sel == b_sel);
`ifdef ALU_ARB_OVF_TRAP_EN
        alu_data = alu_ovf ? '0 : sum[DW-1:0];
`else
        alu_data = sum[DW-1:0];
`endif
    end

    // Response slots and round-robin pointer; a grant reloads only its own slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_zero  <= '0;
            rsp_ovf   <= '0;
            ptr_q     <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    rsp_valid[i]          <= 1'b1;
                    rsp_data[i*DW +: DW]  <= alu_data;
                    rsp_zero[i]           <= alu_zero;
                    rsp_ovf[i]            <= alu_ovf;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
            if (grant_any) begin
                ptr_q <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PW'(1);
            end
        end
    end

endmodule
